// File: rtl/bit_serial_deserializer.sv
// LSB-first serial-to-parallel receiver with a valid/ready word handshake
// and a sticky overrun flag for frame starts that could not be taken.
module bit_serial_deserializer #(
  parameter int WL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sbit,
  input  logic          out_ready,
  input  logic          clr_err,
  output logic [WL-1:0] word,
  output logic          word_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int CW = $clog2(WL);
  localparam logic [CW-1:0] LAST = CW'(WL - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state, state_nx;
  logic [WL-1:0] sr;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic          capture;
  logic          set_ovr;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    capture    = 1'b0;
    set_ovr    = 1'b0;
    busy       = 1'b0;
    word_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          bit_cnt_nx = CW'(1);
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        capture = 1'b1;
        set_ovr = start;
        if (bit_cnt == LAST) begin
          bit_cnt_nx = '0;
          state_nx   = HOLD;
        end else begin
          bit_cnt_nx = bit_cnt + CW'(1);
        end
      end
      HOLD: begin
        word_valid = 1'b1;
        if (out_ready) begin
          // accepting the word frees sr, so a coincident start begins the next frame
          if (start) begin
            capture    = 1'b1;
            bit_cnt_nx = CW'(1);
            state_nx   = SHIFT;
          end else begin
            state_nx = IDLE;
          end
        end else if (start) begin
          set_ovr = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      if (capture) sr <= {sbit, sr[WL-1:1]};
      if (set_ovr)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  assign word = sr;

endmodule

// File: tb/tb_bit_serial_deserializer.sv
// Self-checking bench: expected words are queued as frames are driven and
// compared when the receiver hands a word over (word_valid && out_ready).
module tb_bit_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sbit, out_ready, clr_err;
  logic [3:0] word;
  logic       word_valid, busy, overrun;

  logic       start8, sbit8, out_ready8, clr_err8;
  logic [7:0] word8;
  logic       word_valid8, busy8, overrun8;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic [7:0] exp_q8[$];

  always #5 clk = ~clk;

  bit_serial_deserializer #(.WL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sbit(sbit), .out_ready(out_ready),
    .clr_err(clr_err), .word(word), .word_valid(word_valid), .busy(busy),
    .overrun(overrun)
  );

  bit_serial_deserializer #(.WL(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sbit(sbit8), .out_ready(out_ready8),
    .clr_err(clr_err8), .word(word8), .word_valid(word_valid8), .busy(busy8),
    .overrun(overrun8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake monitors: inputs change 1 time unit after posedge, so negedge sees them stable.
  always @(negedge clk) begin
    if (rst && word_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk("word_out", 32'(word), 32'(exp_q.pop_front()));
    end
    if (rst && word_valid8 && out_ready8) begin
      if (exp_q8.size() == 0) chk("sb8_underflow", 32'(exp_q8.size()), 32'd1);
      else chk("word8_out", 32'(word8), 32'(exp_q8.pop_front()));
    end
  end

  task automatic drive(input logic s, input logic b, input logic r, input logic c);
    start = s; sbit = b; out_ready = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] w, input logic rdy, input string tag);
    exp_q.push_back(w);
    for (int unsigned i = 0; i < 4; i++) begin
      drive(i == 0, w[i], rdy, 1'b0);
      if (i < 3) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nvalid"}, 32'(word_valid), 32'd0);
      end else begin
        chk({tag, "_valid"}, 32'(word_valid), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_word"}, 32'(word), 32'(w));
      end
    end
  endtask

  // Serial sum stream as produced by a bit-serial adder, LSB first.
  task automatic send_sum(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic c;
    logic s;
    c = 1'b0;
    exp_q.push_back(4'(a + b));
    for (int unsigned i = 0; i < 4; i++) begin
      s = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      drive(i == 0, s, 1'b0, 1'b0);
    end
    chk({tag, "_valid"}, 32'(word_valid), 32'd1);
    chk({tag, "_word"}, 32'(word), 32'(4'(a + b)));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 0; sbit = 0; out_ready = 0; clr_err = 0;
    start8 = 0; sbit8 = 0; out_ready8 = 0; clr_err8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;

    // 1: basic frame 1,1,0,1 -> B
    send4(4'hB, 1'b0, "c1");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c1_release_valid", 32'(word_valid), 32'd0);
    chk("c1_release_busy", 32'(busy), 32'd0);

    // 2: backpressure
    send4(4'h6, 1'b0, "c2");
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("c2_hold_word", 32'(word), 32'h6);
      chk("c2_hold_valid", 32'(word_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c2_release_valid", 32'(word_valid), 32'd0);
    chk("c2_release_busy", 32'(busy), 32'd0);

    // 3: back-to-back, start in the HOLD cycle
    send4(4'hA, 1'b1, "c3a");
    send4(4'h5, 1'b1, "c3b");
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c3_ovr", 32'(overrun), 32'd0);
    chk("c3_idle_valid", 32'(word_valid), 32'd0);

    // 4: overrun in SHIFT and in HOLD, clear, and set-wins-over-clear
    exp_q.push_back(4'h9);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("c4_pre_ovr", 32'(overrun), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c4_shift_ovr", 32'(overrun), 32'd1);
    chk("c4_shift_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("c4_word", 32'(word), 32'h9);
    chk("c4_valid", 32'(word_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c4_clr", 32'(overrun), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c4_hold_ovr", 32'(overrun), 32'd1);
    chk("c4_hold_word", 32'(word), 32'h9);
    chk("c4_hold_valid", 32'(word_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c4_clr2", 32'(overrun), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("c4_set_wins", 32'(overrun), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c4_clr3", 32'(overrun), 32'd0);
    chk("c4_word_kept", 32'(word), 32'h9);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // 5: asynchronous reset mid-frame, then a clean frame
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("c5_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("c5_async_word", 32'(word), 32'd0);
    chk("c5_async_busy", 32'(busy), 32'd0);
    chk("c5_async_valid", 32'(word_valid), 32'd0);
    chk("c5_async_ovr", 32'(overrun), 32'd0);
    #1 rst = 1'b1;
    send4(4'h3, 1'b0, "c5");
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // 6: serial adder sums, with wrap-around
    send_sum(4'd5, 4'd6, "c6a");
    send_sum(4'd9, 4'd8, "c6b");

    // 6: WL=8 frame
    begin
      logic [7:0] w8;
      w8 = 8'hCB;
      exp_q8.push_back(w8);
      for (int unsigned i = 0; i < 8; i++) begin
        start8 = (i == 0); sbit8 = w8[i]; out_ready8 = 1'b0; clr_err8 = 1'b0;
        @(posedge clk);
        #1;
        if (i < 7) chk("c8_busy", 32'(busy8), 32'd1);
        else begin
          chk("c8_valid", 32'(word_valid8), 32'd1);
          chk("c8_word", 32'(word8), 32'(w8));
        end
      end
      start8 = 1'b0; out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      chk("c8_release", 32'(word_valid8), 32'd0);
      out_ready8 = 1'b0;
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("q8_empty", 32'(exp_q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
